socdebug_stream_arbiter: RTL and testbench
==========================================

Name: socdebug_stream_arbiter

Overview:
Packet-level round-robin arbiter that shares one byte-wide AXI-Stream channel between NUM_REQ requesters. The shared channel is the host-bound RXD stream into the FT1248 serial controller. Requesters are the ADP controller, trace and status sources. A grant is held for a whole packet (until tlast) or until MAX_BURST beats, whichever comes first. Output is one registered stage, so the controller's late, pulsed tready never stalls the sources combinationally.

Parameters:
NUM_REQ, 2, number of requesters (2..4).
MAX_BURST, 16, beats per grant before forced re-arbitration; 0 = unlimited (packet lock only); max 255.
TAG_BASE, 8'hF0, channel tag base; low 2 bits must be 0 (used only with the optional feature).

Ports:
clk  in  1  system clock.
reset  in  1  synchronous reset, active high.
s_tvalid  in  NUM_REQ  per-requester valid.
s_tdata  in  8*NUM_REQ  per-requester data; requester i on bits [8i+7:8i].
s_tlast  in  NUM_REQ  per-requester end of packet.
s_tready  out  NUM_REQ  per-requester ready; at most one bit high.
m_tvalid  out  1  to FT1248 controller rxd_tvalid.
m_tdata  out  8  to rxd_tdata.
m_tlast  out  1  to rxd_tlast.
m_tready  in  1  from rxd_tready.
grant_o  out  2  index of the current/last granted requester.
busy_o  out  1  high while in ARB_TAG or ARB_XFER.

Behaviour:
- Interface (decided): one clock, clk; reset is synchronous and active-high.
- Reset values:
  - m_tvalid = 0, m_tdata = 0, m_tlast = 0.
  - s_tready = 0, grant_o = 0, busy_o = 0.
  - Round-robin pointer = 0, burst count = 0, state = ARB_IDLE.
- Reset mid-operation discards any held output beat and aborts the grant. Upstream sources see no handshake on the aborted beat.
- Output register (1 entry):
  - Loads when empty or when m_tready is high in the same cycle. This gives 1 beat/cycle throughput.
  - m_tvalid holds until m_tready; m_tdata and m_tlast are stable while m_tvalid && !m_tready.
  - Latency: beat accepted on s_* at cycle N appears on m_* at cycle N+1.
- Let free = !m_tvalid | m_tready.
- State machine:
  - ARB_IDLE:
    - s_tready = 0.
    - If any s_tvalid is high, select the first set bit at or after the pointer (circular, pointer, pointer+1, …). Latch it into grant_o and clear the burst count.
    - Go to ARB_TAG if the optional feature is compiled in, else ARB_XFER.
    - Arbitration decision costs one idle cycle.
  - ARB_TAG (feature only):
    - When free, load {TAG_BASE[7:2], grant_o} with tlast = 0, then go to ARB_XFER.
  - ARB_XFER:
    - s_tready[grant_o] = free; all other bits 0.
    - On each accepted beat (s_tvalid[g] & s_tready[g]): load s_tdata/s_tlast into the output register and increment the burst count.
    - End of grant when the accepted beat has tlast = 1, or when MAX_BURST != 0 and the count reaches MAX_BURST.
    - At end of grant: pointer = (grant_o+1) mod NUM_REQ, go to ARB_IDLE.
- Forced MAX_BURST cut: m_tlast still carries the source tlast (not forced to 1). The remainder of the packet competes again in ARB_IDLE.
- Granted source deasserting tvalid mid-packet: grant is held indefinitely; there is no timeout.
- Non-granted requests never see s_tready and never lose data.
- Burst count is 8 bits with no wrap; when MAX_BURST = 0 it saturates at 255.
- When the last accepted beat ends the grant, the output register still drains normally in ARB_IDLE.

Optional Feature:
Macro: SOCDEBUG_ARB_TAG_EN.
- Defined: ARB_TAG state is present. Each grant emits one tag byte, TAG_BASE | index, ahead of the payload, so the host can demultiplex channels. This adds one beat per grant, including each MAX_BURST continuation.
- Undefined: ARB_TAG is absent and the output stream is payload only, byte-identical to the source packets.

Test Plan:
- Reset, then a single source s0 sends a 3-byte packet 11,22,33 with tlast on 33 and m_tready held at 1 → m_* shows 11,22,33 on consecutive cycles, m_tlast only on 33. Then busy_o = 0, pointer = 1.
- s0 and s1 both valid continuously, each sending 2-byte packets (s0: A0,A1; s1: B0,B1) → output order A0,A1,B0,B1,A0,A1… and s_tready is never high on both bits.
- MAX_BURST = 4; s0 sends an 8-byte packet 00..07 while s1 has a pending packet → 00..03, then s1's packet, then 04..07. m_tlast is high only on 07 and on s1's last beat.
- m_tready low for 5 cycles while m_tvalid = 1 with data 5A → m_tdata stays 5A and s_tready[g] = 0 throughout. The next beat is accepted in the same cycle m_tready rises, with no bubble.
- Reset asserted for 1 cycle in mid-packet with an output beat pending → the next cycle shows m_tvalid = 0, grant_o = 0, busy_o = 0, and the source's held beat is not consumed.
- SOCDEBUG_ARB_TAG_EN defined, TAG_BASE = F0, s1 sends 1-byte packet 7E (tlast) → m_* shows F1 (tlast = 0) then 7E (tlast = 1).

Source files
------------

// File: rtl/socdebug_stream_arbiter.sv
// Packet-level round-robin arbiter merging NUM_REQ byte streams onto one registered output.
// Optional channel tag byte per grant when SOCDEBUG_ARB_TAG_EN is defined.
module socdebug_stream_arbiter #(
  parameter int         NUM_REQ   = 2,
  parameter int         MAX_BURST = 16,
  parameter logic [7:0] TAG_BASE  = 8'hF0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     s_tvalid,
  input  logic [8*NUM_REQ-1:0]   s_tdata,
  input  logic [NUM_REQ-1:0]     s_tlast,
  output logic [NUM_REQ-1:0]     s_tready,
  output logic                   m_tvalid,
  output logic [7:0]             m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [1:0]             grant_o,
  output logic                   busy_o
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
    $error("socdebug_stream_arbiter: NUM_REQ must be 2..4");
  end
  if (MAX_BURST < 0 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("socdebug_stream_arbiter: MAX_BURST must be 0..255");
  end
  if (TAG_BASE[1:0] != 2'b00) begin : g_bad_tag_base
    $error("socdebug_stream_arbiter: TAG_BASE low bits must be zero");
  end

`ifdef SOCDEBUG_ARB_TAG_EN
  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_TAG = 2'd1, ARB_XFER = 2'd2} arb_state_t;
`else
  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_XFER = 2'd2} arb_state_t;
`endif

  arb_state_t           state_reg;
  logic [1:0]           ptr_reg;
  logic [1:0]           grant_reg;
  logic [7:0]           burst_cnt_reg;

  logic [7:0]           data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]   grant_hot;
  logic [7:0]           sel_data;
  logic                 sel_valid;
  logic                 sel_last;
  logic [1:0]           pick;
  logic                 free;
  logic                 xfer_ready;
  logic                 s_fire;
  logic                 burst_done;
  logic [7:0]           burst_cnt_next;
  logic [1:0]           ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi]  = s_tdata[8*gi +: 8];
      assign grant_hot[gi] = (grant_reg == 2'(gi));
      assign s_tready[gi]  = xfer_ready & grant_hot[gi];
    end
  endgenerate

  assign free       = !m_tvalid | m_tready;
  // Reset gates ready so an aborted beat never handshakes upstream.
  assign xfer_ready = (state_reg == ARB_XFER) && free && !reset;
  assign sel_valid  = |(s_tvalid & grant_hot);
  assign sel_last   = |(s_tlast & grant_hot);
  assign s_fire     = xfer_ready & sel_valid;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_hot[k]) sel_data = sel_data | data_arr[k];
    end
  end

  // Scan downwards so the requester nearest the pointer overwrites the others.
  always_comb begin
    int idx;
    pick = '0;
    idx  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (s_tvalid[idx]) pick = 2'(idx);
    end
  end

  assign burst_cnt_next = (burst_cnt_reg == 8'hFF) ? 8'hFF : burst_cnt_reg + 8'd1;
  assign burst_done     = (MAX_BURST != 0) && (({1'b0, burst_cnt_reg} + 9'd1) == 9'(MAX_BURST));
  assign ptr_next       = (grant_reg == LAST_IDX) ? 2'd0 : grant_reg + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ARB_IDLE;
      ptr_reg       <= '0;
      grant_reg     <= '0;
      burst_cnt_reg <= '0;
      m_tvalid      <= 1'b0;
      m_tdata       <= '0;
      m_tlast       <= 1'b0;
    end else begin
      if (m_tready) m_tvalid <= 1'b0;
      case (state_reg)
        ARB_IDLE: begin
          if (|s_tvalid) begin
            grant_reg     <= pick;
            burst_cnt_reg <= '0;
`ifdef SOCDEBUG_ARB_TAG_EN
            state_reg     <= ARB_TAG;
`else
            state_reg     <= ARB_XFER;
`endif
          end
        end
`ifdef SOCDEBUG_ARB_TAG_EN
        ARB_TAG: begin
          if (free) begin
            m_tvalid  <= 1'b1;
            m_tdata   <= {TAG_BASE[7:2], grant_reg};
            m_tlast   <= 1'b0;
            state_reg <= ARB_XFER;
          end
        end
`endif
        ARB_XFER: begin
          if (s_fire) begin
            m_tvalid      <= 1'b1;
            m_tdata       <= sel_data;
            m_tlast       <= sel_last;
            burst_cnt_reg <= burst_cnt_next;
            if (sel_last || burst_done) begin
              ptr_reg   <= ptr_next;
              state_reg <= ARB_IDLE;
            end
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

  assign grant_o = grant_reg;
  assign busy_o  = (state_reg != ARB_IDLE);

endmodule

// File: tb/tb_socdebug_stream_arbiter.sv
// Bench for socdebug_stream_arbiter: queue-driven sources, grant-level reference model, scoreboard.
module tb_socdebug_stream_arbiter;

  localparam int N  = 3;
  localparam int MB = 4;
  localparam logic [7:0] TAGB = 8'hF0;
`ifdef SOCDEBUG_ARB_TAG_EN
  localparam int TAGN = 1;
`else
  localparam int TAGN = 0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   s_tvalid;
  logic [8*N-1:0] s_tdata;
  logic [N-1:0]   s_tlast;
  logic [N-1:0]   s_tready;
  logic           m_tvalid;
  logic [7:0]     m_tdata;
  logic           m_tlast;
  logic           m_tready;
  logic [1:0]     grant_o;
  logic           busy_o;

  socdebug_stream_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .TAG_BASE(TAGB)) dut (
    .clk(clk), .reset(reset),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Beats are {tlast, data}.
  logic [8:0] src_q [N][$];
  logic [8:0] exp_q [$];
  logic [8:0] got_q [$];
  int         out_cyc [$];
  int         acc_cyc [$];
  int         cyc = 0;
  int         model_ptr = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         tready_mode = 0;
  logic       tready_fixed = 1'b1;

  function automatic bit src_busy();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_inputs();
    logic [8:0] b;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0) begin
        b = src_q[i][0];
        s_tvalid[i] = 1'b1;
        s_tdata[8*i +: 8] = b[7:0];
        s_tlast[i] = b[8];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tdata[8*i +: 8] = 8'h00;
        s_tlast[i] = 1'b0;
      end
    end
  endtask

  task automatic clear_sb();
    exp_q.delete(); got_q.delete(); out_cyc.delete(); acc_cyc.delete();
  endtask

  // Grant-level model: every source with data is valid, winner is the first non-empty
  // queue at or after the pointer, a grant ends on tlast or after MB beats.
  task automatic build_expected();
    logic [8:0] cq [N][$];
    logic [8:0] b;
    int g, cnt;
    bit any;
    for (int i = 0; i < N; i++) cq[i] = src_q[i];
    forever begin
      any = 1'b0;
      g = 0;
      for (int k = N - 1; k >= 0; k--) begin
        if (cq[(model_ptr + k) % N].size() != 0) begin
          g = (model_ptr + k) % N;
          any = 1'b1;
        end
      end
      if (!any) break;
      if (TAGN == 1) exp_q.push_back({1'b0, TAGB[7:2], 2'(g)});
      cnt = 0;
      do begin
        b = cq[g].pop_front();
        exp_q.push_back(b);
        cnt++;
      end while (!b[8] && cnt != MB && cq[g].size() != 0);
      model_ptr = (g + 1) % N;
    end
  endtask

  task automatic tick();
    logic [N-1:0] fire;
    logic [8:0]   e;
    @(negedge clk);
    vectors++;
    if ($countones(s_tready) > 1) begin
      miscompares++;
      $display("FAIL onehot_ready: s_tready=%b, required at most one bit set", s_tready);
    end
    fire = s_tvalid & s_tready;
    if (fire != 0) begin
      vectors++;
      if (fire !== (3'b001 << grant_o)) begin
        miscompares++;
        $display("FAIL grant_match: handshake=%b grant_o=%0d, required handshake only on granted source", fire, grant_o);
      end
      acc_cyc.push_back(cyc);
    end
    if (m_tvalid && m_tready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_beat: got %h, required no beat", {m_tlast, m_tdata});
      end else begin
        e = exp_q.pop_front();
        if ({m_tlast, m_tdata} !== e) begin
          miscompares++;
          $display("FAIL out_beat: got last=%b data=%h, required last=%b data=%h", m_tlast, m_tdata, e[8], e[7:0]);
        end
      end
      got_q.push_back({m_tlast, m_tdata});
      out_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++) if (fire[i]) void'(src_q[i].pop_front());
    drive_inputs();
    m_tready = (tready_mode != 0) ? ($urandom_range(0, 3) != 0) : tready_fixed;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || src_busy()) && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d beats outstanding after %0d cycles, required 0", exp_q.size(), budget);
    end
    vectors++;
    if (busy_o !== 1'b0 || m_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_drain: busy_o=%b m_tvalid=%b, required 0 0", busy_o, m_tvalid);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_tready = 1'b0;
    s_tvalid = '0; s_tdata = '0; s_tlast = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({m_tvalid, m_tdata, m_tlast, s_tready, grant_o, busy_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: m_tvalid=%b m_tdata=%h m_tlast=%b s_tready=%b grant_o=%0d busy_o=%b, required all 0",
               m_tvalid, m_tdata, m_tlast, s_tready, grant_o, busy_o);
    end
    reset = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_single_packet();
    clear_sb();
    tready_mode = 0; tready_fixed = 1'b1; m_tready = 1'b1;
    src_q[0].push_back(9'h011); src_q[0].push_back(9'h022); src_q[0].push_back(9'h133);
    build_expected();
    drive_inputs();
    drain(100);
    vectors++;
    if (out_cyc.size() != 3 + TAGN || acc_cyc.size() != 3) begin
      miscompares++;
      $display("FAIL single_count: out=%0d acc=%0d, required %0d and 3", out_cyc.size(), acc_cyc.size(), 3 + TAGN);
    end else begin
      vectors++;
      if (out_cyc[TAGN] != acc_cyc[0] + 1) begin
        miscompares++;
        $display("FAIL single_latency: out cycle %0d, required %0d", out_cyc[TAGN], acc_cyc[0] + 1);
      end
      vectors++;
      if (out_cyc[TAGN+1] != out_cyc[TAGN] + 1 || out_cyc[TAGN+2] != out_cyc[TAGN] + 2) begin
        miscompares++;
        $display("FAIL single_back_to_back: cycles %0d %0d %0d, required consecutive",
                 out_cyc[TAGN], out_cyc[TAGN+1], out_cyc[TAGN+2]);
      end
    end
    vectors++;
    if (grant_o !== 2'd0) begin
      miscompares++;
      $display("FAIL single_grant: grant_o=%0d, required 0", grant_o);
    end
  endtask

  task automatic test_two_sources();
    clear_sb();
    for (int p = 0; p < 2; p++) begin
      src_q[0].push_back(9'h0A0); src_q[0].push_back(9'h1A1);
      src_q[1].push_back(9'h0B0); src_q[1].push_back(9'h1B1);
    end
    build_expected();
    drive_inputs();
    drain(200);
`ifndef SOCDEBUG_ARB_TAG_EN
    vectors++;
    if (got_q.size() < 1 || got_q[0] !== 9'h0B0) begin
      miscompares++;
      $display("FAIL rr_pointer: first beat %h, required 0B0 (pointer 1 after s0 packet)",
               (got_q.size() > 0) ? got_q[0] : 9'h1FF);
    end
`endif
  endtask

  task automatic test_max_burst();
    apply_reset();
    clear_sb();
    for (int b = 0; b < 8; b++) src_q[0].push_back({(b == 7), 8'(b)});
    src_q[1].push_back(9'h0C0); src_q[1].push_back(9'h0C1); src_q[1].push_back(9'h1C2);
    build_expected();
    drive_inputs();
    drain(200);
`ifndef SOCDEBUG_ARB_TAG_EN
    vectors++;
    if (got_q.size() != 11 || got_q[3] !== 9'h003 || got_q[4] !== 9'h0C0 || got_q[10] !== 9'h107) begin
      miscompares++;
      $display("FAIL burst_cut: n=%0d, required 11 beats with 003 cut, C0 at 4, 107 last", got_q.size());
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [8:0] hold;
    int n = 0;
    clear_sb();
    tready_fixed = 1'b0; m_tready = 1'b0;
    src_q[0].push_back(9'h05A); src_q[0].push_back(9'h05B); src_q[0].push_back(9'h15C);
    build_expected();
    hold = exp_q[0];
    drive_inputs();
    while (!m_tvalid && n < 20) begin tick(); n++; end
    for (int j = 0; j < 5; j++) begin
      vectors++;
      if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== hold || s_tready !== '0) begin
        miscompares++;
        $display("FAIL hold_stall: valid=%b beat=%h s_tready=%b, required 1 %h 000", m_tvalid, {m_tlast, m_tdata}, s_tready, hold);
      end
      tick();
    end
    tready_fixed = 1'b1; m_tready = 1'b1;
    #1;
    vectors++;
    if (s_tready !== 3'b001) begin
      miscompares++;
      $display("FAIL no_bubble: s_tready=%b, required 001 when m_tready rises", s_tready);
    end
    drain(100);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    logic [N-1:0] fire;
    clear_sb();
    tready_fixed = 1'b0; m_tready = 1'b0;
    src_q[1].push_back(9'h010); src_q[1].push_back(9'h011);
    src_q[1].push_back(9'h012); src_q[1].push_back(9'h113);
    drive_inputs();
    while (!m_tvalid && n < 20) begin tick(); n++; end
    reset = 1'b1;
    @(negedge clk);
    fire = s_tvalid & s_tready;
    vectors++;
    if (fire !== '0) begin
      miscompares++;
      $display("FAIL reset_no_handshake: handshake=%b, required 000", fire);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_ptr = 0;
    vectors++;
    if (m_tvalid !== 1'b0 || grant_o !== 2'd0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort: m_tvalid=%b grant_o=%0d busy_o=%b, required 0 0 0", m_tvalid, grant_o, busy_o);
    end
    tready_fixed = 1'b1; m_tready = 1'b1;
    build_expected();
    drive_inputs();
    drain(100);
  endtask

`ifdef SOCDEBUG_ARB_TAG_EN
  task automatic test_tag();
    apply_reset();
    clear_sb();
    src_q[1].push_back(9'h17E);
    build_expected();
    drive_inputs();
    drain(50);
    vectors++;
    if (got_q.size() != 2 || got_q[0] !== 9'h0F1 || got_q[1] !== 9'h17E) begin
      miscompares++;
      $display("FAIL tag_byte: n=%0d, required 0F1 then 17E", got_q.size());
    end
  endtask
`endif

  task automatic test_random();
    int np, len;
    tready_mode = 1;
    for (int r = 0; r < 6; r++) begin
      clear_sb();
      for (int i = 0; i < N; i++) begin
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 9);
          for (int b = 0; b < len; b++) src_q[i].push_back({(b == len - 1), 8'($urandom)});
        end
      end
      build_expected();
      drive_inputs();
      drain(3000);
    end
    tready_mode = 0; tready_fixed = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    m_tready = 1'b0;
    s_tvalid = '0; s_tdata = '0; s_tlast = '0;
    test_reset();
    test_single_packet();
    test_two_sources();
    test_max_burst();
    test_backpressure();
    test_reset_mid();
`ifdef SOCDEBUG_ARB_TAG_EN
    test_tag();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
